// File: rtl/sub_bytes_folded.sv
// Folded AES SubBytes/InvSubBytes engine: LANES S-box lookups per cycle, STEPS cycles per block.
// Optional macro SUBBYTES_INV_EN adds inverse S-box lanes selected by the per-block inv input.
module sub_bytes_folded #(
    parameter int DATA_W = 128,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic              inv,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
);
    localparam int NO_BYTES = DATA_W >> 3;
    localparam int STEPS    = NO_BYTES / LANES;
    localparam int CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // S-box built from the GF(2^8) inverse plus the affine map, so no tables are needed.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 equals x^-1 for nonzero x and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

`ifdef SUBBYTES_INV_EN
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction
`endif

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] work_reg;
    logic [DATA_W-1:0] work_next;
    logic [DATA_W-1:0] data_reg;
    logic              accept;
    logic              last_step;
    logic [7:0]        lane_in  [LANES];
    logic [7:0]        lane_out [LANES];

`ifdef SUBBYTES_INV_EN
    logic mode_reg;
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = valid_in && in_ready;
    assign valid_out = (state_reg == DONE);
    assign data_out  = data_reg;
    assign last_step = (cnt_reg == CNT_W'(STEPS - 1));

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_in[gi] = work_reg[(int'(cnt_reg) * LANES + gi) * 8 +: 8];
`ifdef SUBBYTES_INV_EN
            assign lane_out[gi] = mode_reg ? inv_sbox(lane_in[gi]) : fwd_sbox(lane_in[gi]);
`else
            assign lane_out[gi] = fwd_sbox(lane_in[gi]);
`endif
        end
    endgenerate

    always_comb begin
        work_next = work_reg;
        for (int i = 0; i < LANES; i++) begin
            work_next[(int'(cnt_reg) * LANES + i) * 8 +: 8] = lane_out[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            work_reg  <= '0;
            data_reg  <= '0;
`ifdef SUBBYTES_INV_EN
            mode_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (accept) begin
                        work_reg  <= data_in;
`ifdef SUBBYTES_INV_EN
                        mode_reg  <= inv;
`endif
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end else if (state_reg == DONE && out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                BUSY: begin
                    work_reg <= work_next;
                    if (last_step) begin
                        // Only a fully substituted block ever reaches the output register.
                        data_reg  <= work_next;
                        cnt_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_bytes_folded.sv
// Scoreboard bench for sub_bytes_folded: main LANES=4 instance plus LANES=1/16 latency instances.
module tb_sub_bytes_folded;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         valid_in, inv, out_ready;
    logic [127:0] data_in;
    logic         in_ready, valid_out;
    logic [127:0] data_out;

    logic         x_valid, x_inv;
    logic [127:0] x_data;
    logic         r1, v1, r16, v16;
    logic [127:0] d1, d16;

    sub_bytes_folded #(.DATA_W(128), .LANES(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready), .inv(inv),
        .data_in(data_in), .valid_out(valid_out), .out_ready(out_ready), .data_out(data_out)
    );
    sub_bytes_folded #(.DATA_W(128), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .valid_in(x_valid), .in_ready(r1), .inv(x_inv),
        .data_in(x_data), .valid_out(v1), .out_ready(1'b1), .data_out(d1)
    );
    sub_bytes_folded #(.DATA_W(128), .LANES(16)) dut_l16 (
        .clk(clk), .reset(reset), .valid_in(x_valid), .in_ready(r16), .inv(x_inv),
        .data_in(x_data), .valid_out(v16), .out_ready(1'b1), .data_out(d16)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfers = 0;
    logic [127:0] exp_q[$];
    int acc_q[$];
    logic vo_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: records accepting edges, checks latency on each valid_out rise, pops data on handshake.
    always @(negedge clk) begin
        int a;
        logic [127:0] e;
        if (!reset) begin
            if (valid_in && in_ready) acc_q.push_back(cyc + 1);
            if (valid_out && !vo_prev) begin
                if (acc_q.size() == 0) begin
                    check("latency_no_accept", 128'd1, 128'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("latency", 128'(cyc - a), 128'd4);
                end
            end
            if (valid_out && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", data_out, 128'hx);
                end else begin
                    e = exp_q.pop_front();
                    xfers++;
                    $display("xfer %0d data_out=%h expected=%h", xfers, data_out, e);
                    check("data", data_out, e);
                end
            end
        end
        vo_prev <= valid_out;
    end

    task automatic send(input logic [127:0] d, input logic iv, input logic [127:0] e);
        bit done = 0;
        valid_in = 1'b1;
        data_in  = d;
        inv      = iv;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        inv      = 1'($urandom);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat1, lat16;
        reset = 1'b1; valid_in = 1'b1; data_in = {16{8'hff}}; inv = 1'b0; out_ready = 1'b1;
        x_valid = 1'b0; x_inv = 1'b0; x_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid_out", 128'(valid_out), 128'd0);
        valid_in = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_data_out", data_out, 128'd0);
        repeat (2) @(negedge clk);
        check("no_accept_in_reset", 128'({valid_out, in_ready}), 128'b01);
        @(posedge clk);
        #1;

        // Forward vector, then two blocks back to back (second accepted from DONE).
        send(FIPS_IN, 1'b0, FIPS_OUT);
        wait_drain();
        send({16{8'hff}}, 1'b0, {16{8'h16}});
        send({16{8'h00}}, 1'b0, {16{8'h63}});
        wait_drain();
        send({16{8'h53}}, 1'b0, {16{8'hed}});
`ifdef SUBBYTES_INV_EN
        send(FIPS_OUT, 1'b1, FIPS_IN);
        send({8{16'h63ed}}, 1'b1, {8{16'h0053}});
        send({16{8'h53}}, 1'b1, {16{8'h50}});
`else
        send({8{16'h63ed}}, 1'b1, {8{16'hfb55}});
        send({16{8'h53}}, 1'b1, {16{8'hed}});
`endif
        wait_drain();

        // Backpressure with a pending block.
        out_ready = 1'b0;
        send({16{8'h01}}, 1'b0, {16{8'h7c}});
        for (int k = 0; k < 50 && !valid_out; k++) @(negedge clk);
        check("bp_reach_done", 128'(valid_out), 128'd1);
        @(posedge clk);
        #1;
        fork
            send({16{8'hff}}, 1'b0, {16{8'h16}});
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("bp_valid_hold", 128'(valid_out), 128'd1);
                    check("bp_data_hold", data_out, {16{8'h7c}});
                    check("bp_in_ready", 128'(in_ready), 128'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_release_ready", 128'(in_ready), 128'd1);
                @(posedge clk);
                #1;
                check("bp_same_edge", 128'({valid_out, in_ready}), 128'b00);
            end
        join
        wait_drain();

        // Reset during BUSY step 2 aborts the block.
        send(FIPS_IN, 1'b0, FIPS_OUT);
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_ready", 128'(in_ready), 128'd0);
        reset = 1'b1;
        #1;
        check("abort_async", 128'({valid_out, in_ready}), 128'b01);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send({16{8'h00}}, 1'b0, {16{8'h63}});
        wait_drain();

        // LANES=1 and LANES=16 latency.
        x_valid = 1'b1; x_data = FIPS_IN; x_inv = 1'b0;
        check("lanes_idle", 128'({r1, r16}), 128'b11);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        lat1 = -1;
        lat16 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (v16 && lat16 < 0) begin
                lat16 = c;
                $display("xfer lanes16 data_out=%h cycles=%0d", d16, c);
                check("l16_data", d16, FIPS_OUT);
            end
            if (v1 && lat1 < 0) begin
                lat1 = c;
                $display("xfer lanes1 data_out=%h cycles=%0d", d1, c);
                check("l1_data", d1, FIPS_OUT);
            end
        end
        check("l16_latency", 128'(lat16), 128'd1);
        check("l1_latency", 128'(lat1), 128'd16);

        wait_drain();
        check("scoreboard_accepts", 128'(acc_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
